// File: rtl/syn_gpu_pkg.sv
// syn_gpu_pkg: shared GPU job types, scheduler FSM encoding and default parameters.
package syn_gpu_pkg;
  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [7:0]  color;
  } gpu_draw_job_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} sched_fsm_t;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_TMO_W      = 16;
endpackage

// File: rtl/syn_gpu_job_fifo.sv
// syn_gpu_job_fifo: register-array FIFO with wrap-bit pointers, flush, full/empty and count.
module syn_gpu_job_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         wr, rd;
  assign cnt   = wp - rp;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign wr    = push & ~full & ~flush;
  assign rd    = pop & ~empty & ~flush;
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/syn_gpu_job_sched.sv
// syn_gpu_job_sched: queues draw jobs and dispatches them one at a time to the euclid engine.
// Optional watchdog enabled by defining SYN_GPU_JOB_SCHED_TIMEOUT_EN.
module syn_gpu_job_sched
  import syn_gpu_pkg::*;
#(
  parameter int unsigned P_FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned P_CNT_W      = DEF_CNT_W,
  parameter int unsigned P_TMO_W      = DEF_TMO_W
) (
  input  logic                            clk_ir,
  input  logic                            rst_ih,
  input  logic                            job_push_i,
  input  gpu_draw_job_t                   job_data_i,
  output logic                            job_full_o,
  output logic [$clog2(P_FIFO_DEPTH):0]   job_cnt_o,
  output logic                            job_ovrflw_o,
  input  logic                            flush_i,
  output logic                            euclid_job_start_o,
  output gpu_draw_job_t                   euclid_job_data_o,
  input  logic                            euclid_busy_i,
  input  logic                            euclid_job_done_i,
  output logic                            sched_busy_o,
  output logic [P_CNT_W-1:0]              jobs_done_o,
  output logic                            tmo_err_o
);
  sched_fsm_t    state, nxt;
  gpu_draw_job_t head;
  logic          empty, pop, tmo_hit, done_ok;

  syn_gpu_job_fifo #(.DEPTH(P_FIFO_DEPTH), .W($bits(gpu_draw_job_t))) u_fifo (
    .clk(clk_ir), .rst(rst_ih), .push(job_push_i), .pop(pop), .flush(flush_i),
    .din(job_data_i), .dout(head), .full(job_full_o), .empty(empty), .cnt(job_cnt_o)
  );

  assign pop          = state == IDLE && !empty && !euclid_busy_i && !flush_i;
  assign done_ok      = state == WAIT_DONE && euclid_job_done_i;
  assign sched_busy_o = state != IDLE || job_cnt_o != '0;

  always_ff @(posedge clk_ir) begin
    state <= rst_ih ? IDLE : nxt;
  end

  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (pop ? ISSUE : IDLE) :
          state == ISSUE ? WAIT_DONE :
          (done_ok || tmo_hit) ? IDLE : WAIT_DONE;
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      euclid_job_start_o <= 1'b0;
      euclid_job_data_o  <= '0;
      jobs_done_o        <= '0;
      job_ovrflw_o       <= 1'b0;
    end else begin
      euclid_job_start_o <= pop;
      if (pop) euclid_job_data_o <= head;
      if (done_ok) jobs_done_o <= jobs_done_o + 1'b1;
      job_ovrflw_o <= !flush_i && (job_ovrflw_o || (job_push_i && job_full_o));
    end
  end

`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
  logic [P_TMO_W-1:0] tmo_cnt, tmo_inc;
  assign tmo_inc = tmo_cnt + 1'b1;
  // Fires as the counter steps onto all-ones, so the engine gets 2^P_TMO_W-1 cycles.
  assign tmo_hit = state == WAIT_DONE && !euclid_job_done_i && &tmo_inc;
  always_ff @(posedge clk_ir) begin
    tmo_cnt   <= (rst_ih || state != WAIT_DONE) ? '0 : tmo_inc;
    tmo_err_o <= !rst_ih && !flush_i && (tmo_err_o || tmo_hit);
  end
`else
  assign tmo_hit   = 1'b0;
  assign tmo_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_syn_gpu_job_sched.sv
// tb_syn_gpu_job_sched: directed self-checking bench for the GPU job scheduler.
module tb_syn_gpu_job_sched;
  import syn_gpu_pkg::*;
  logic          clk = 0;
  logic          rst = 1;
  logic          push = 0, flush = 0, e_busy = 0, e_done = 0;
  gpu_draw_job_t din = '0;
  logic          full, ovrflw, start, s_busy, tmo_err;
  logic [3:0]    cnt;
  gpu_draw_job_t e_data, got;
  logic [3:0]    jobs_done;
  int            n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  syn_gpu_job_sched #(.P_FIFO_DEPTH(8), .P_CNT_W(4), .P_TMO_W(4)) dut (
    .clk_ir(clk), .rst_ih(rst), .job_push_i(push), .job_data_i(din),
    .job_full_o(full), .job_cnt_o(cnt), .job_ovrflw_o(ovrflw), .flush_i(flush),
    .euclid_job_start_o(start), .euclid_job_data_o(e_data), .euclid_busy_i(e_busy),
    .euclid_job_done_i(e_done), .sched_busy_o(s_busy), .jobs_done_o(jobs_done),
    .tmo_err_o(tmo_err)
  );

  task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic gpu_draw_job_t mk(input int n);
    return '{x0: 16'(n), y0: 16'(n * 3), x1: 16'(n + 100), y1: 16'(n * 7), color: 8'(n + 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input gpu_draw_job_t j);
    push = 1;
    din  = j;
    tick();
    push = 0;
  endtask

  task automatic wait_start(output gpu_draw_job_t d);
    int i;
    for (i = 0; i < 40 && !start; i++) tick();
    check("start_seen", start, 1'b1);
    d = e_data;
  endtask

  task automatic done_pulse();
    e_done = 1;
    tick();
    e_done = 0;
  endtask

  task automatic run_job(input int n);
    push_job(mk(n));
    wait_start(got);
    tick();
    done_pulse();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_ovr"}, ovrflw, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_data"}, e_data, 0);
    check({tag, "_sbusy"}, s_busy, 0);
    check({tag, "_done"}, jobs_done, 0);
    check({tag, "_tmo"}, tmo_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 0;
    check_zero("rst");

    // Single job: start two cycles after the push, done ten cycles later
    push_job(mk(1));
    check("a_cnt", cnt, 1);
    check("a_nostart", start, 0);
    tick();
    check("a_start", start, 1);
    check("a_data", e_data, mk(1));
    check("a_cnt0", cnt, 0);
    tick();
    check("a_pulse1", start, 0);
    repeat (8) tick();
    check("a_sbusy_wait", s_busy, 1);
    done_pulse();
    check("a_done", jobs_done, 1);
    check("a_idle", s_busy, 0);

    // Back-pressure then FIFO-order dispatch
    e_busy = 1;
    push_job(mk(2)); push_job(mk(3)); push_job(mk(4));
    repeat (3) tick();
    check("bp_nostart", start, 0);
    check("bp_cnt", cnt, 3);
    e_busy = 0;
    for (int k = 2; k <= 4; k++) begin
      wait_start(got);
      check("bp_order", got, mk(k));
      tick();
      done_pulse();
    end
    check("bp_done", jobs_done, 4);

    // Overflow, overflow with concurrent pop, then flush
    e_busy = 1;
    for (int k = 10; k < 18; k++) push_job(mk(k));
    check("ov_cnt8", cnt, 8);
    check("ov_full", full, 1);
    check("ov_clean", ovrflw, 0);
    push_job(mk(18));
    check("ov_flag", ovrflw, 1);
    check("ov_cnt_keep", cnt, 8);
    e_busy = 0;
    push_job(mk(19));
    check("ov_pop_cnt", cnt, 7);
    check("ov_pop_start", start, 1);
    check("ov_pop_data", e_data, mk(10));
    tick();
    flush = 1;
    push = 1;
    din = mk(20);
    tick();
    flush = 0;
    push = 0;
    check("fl_cnt", cnt, 0);
    check("fl_ovr", ovrflw, 0);
    check("fl_inflight", s_busy, 1);
    done_pulse();
    check("fl_done", jobs_done, 5);
    check("fl_idle", s_busy, 0);
    repeat (3) tick();
    check("fl_nostart", start, 0);

    // Counter wrap and spurious done pulses
    for (int k = 0; k < 10; k++) run_job(30 + k);
    check("wr_15", jobs_done, 15);
    run_job(40);
    check("wr_wrap", jobs_done, 0);
    done_pulse();
    check("sp_idle", jobs_done, 0);
    push_job(mk(41));
    tick();
    check("sp_issue_start", start, 1);
    done_pulse();
    check("sp_issue", jobs_done, 0);
    check("sp_inflight", s_busy, 1);
    done_pulse();
    check("sp_real", jobs_done, 1);

    // Watchdog
    e_busy = 1;
    push_job(mk(50));
    push_job(mk(51));
    e_busy = 0;
    wait_start(got);
    check("to_first", got, mk(50));
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (tmo_err) begin
          n = i;
          break;
        end
      end
      check("to_cycles", n, 16);
      check("to_err", tmo_err, 1);
      check("to_done_keep", jobs_done, 1);
      wait_start(got);
      check("to_next", got, mk(51));
      tick();
      done_pulse();
      check("to_next_done", jobs_done, 2);
      flush = 1;
      tick();
      flush = 0;
      check("to_flush_clr", tmo_err, 0);
    end
`else
    repeat (30) tick();
    check("to_err_off", tmo_err, 0);
    check("to_waiting", s_busy, 1);
    check("to_nostart", start, 0);
    done_pulse();
    wait_start(got);
    check("to_next", got, mk(51));
    tick();
    done_pulse();
    check("to_next_done", jobs_done, 3);
`endif

    // Reset mid-job with two jobs queued
    push_job(mk(60));
    wait_start(got);
    tick();
    push_job(mk(61));
    push_job(mk(62));
    check("rm_cnt", cnt, 2);
    rst = 1;
    tick();
    rst = 0;
    check_zero("rm");
    done_pulse();
    check("rm_done_ign", jobs_done, 0);
    repeat (3) tick();
    check("rm_nostart", start, 0);
    check("rm_idle", s_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
